hilo_muldiv: RTL and testbench

HI/LO register pair with its multiply/divide datapath, sitting directly downstream of the CPU control unit. It consumes the decoded HI_write/LO_write strobes and the instruction funct field, and executes MTHI, MTLO, MULT, MULTU, DIV and DIVU. It holds HI and LO for the MFHI/MFLO writeback mux. A registered busy flag tells the pipeline to pause while a multi-cycle operation is in flight.

---
 rtl/hilo_muldiv.sv | 238 +++++++++++++++++++++++
 tb/tb_hilo_muldiv.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: MIPS HI/LO register pair with its multiply/divide datapath.
// Handles MTHI, MTLO, MULT, MULTU, DIV and DIVU. Multi-cycle operations run
// 32 magnitude iterations and then one sign-fix cycle. While they run, busy
// stays high and hi/lo keep their previous values until the fix cycle.
// Build option: define HILO_FAST_MULT_EN to use a single-cycle 32x32
// multiplier for MULT/MULTU. Divide is the same in both builds.
module hilo_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue,
  input  logic [5:0]  funct,
  input  logic [1:0]  HI_write,
  input  logic [1:0]  LO_write,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // Two's-complement magnitude (or negation) when neg is set.
  function automatic logic [31:0] neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // Conditional 64-bit negation, used for the product sign fix.
  function automatic logic [63:0] neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;     // divide: partial remainder; multiply: upper accumulator
  logic [31:0] quo_q, quo_d;     // divide: dividend/quotient; multiply: multiplier/lower product
  logic [31:0] opb_q, opb_d;     // divisor or multiplicand magnitude
  logic        op_div_q, op_div_d;
  logic        neg_q_q, neg_q_d; // quotient/product must be negated
  logic        neg_r_q, neg_r_d; // remainder must be negated (dividend sign)
  logic        div0_q, div0_d;
  logic [31:0] rs_raw_q, rs_raw_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;

  logic        accept_s;
  logic        start_s;
  logic        sgn_a_s, sgn_b_s;
  logic [32:0] div_shift_s;
  logic [32:0] div_diff_s;
  logic [31:0] div_rem_s, div_quo_s;
  logic [32:0] mul_sum_s;
  logic [31:0] mul_rem_s, mul_quo_s;
  logic [63:0] prod_fix_s;
`ifdef HILO_FAST_MULT_EN
  logic [63:0] prod_s_s, prod_u_s;
`endif

  // Accept decode: valid instruction, not busy, targets HI/LO, known funct.
  always_comb begin
    accept_s = 1'b0;
    if (issue && !busy_q && ((HI_write == 2'b11) || (LO_write == 2'b11))) begin
      case (funct)
        F_MTHI, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU: accept_s = 1'b1;
        default:                                       accept_s = 1'b0;
      endcase
    end else begin
      accept_s = 1'b0;
    end
  end

  // One datapath iteration each for restoring divide and shift-add multiply.
  always_comb begin
    div_shift_s = {rem_q, quo_q[31]};
    div_diff_s  = div_shift_s - {1'b0, opb_q};
    if (div_shift_s >= {1'b0, opb_q}) begin
      div_rem_s = div_diff_s[31:0];
      div_quo_s = {quo_q[30:0], 1'b1};
    end else begin
      div_rem_s = div_shift_s[31:0];
      div_quo_s = {quo_q[30:0], 1'b0};
    end
    mul_sum_s  = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_rem_s  = mul_sum_s[32:1];
    mul_quo_s  = {mul_sum_s[0], quo_q[31:1]};
    prod_fix_s = neg64({rem_q, quo_q}, neg_q_q);
`ifdef HILO_FAST_MULT_EN
    // Low 64 bits of the sign-extended product equal the signed product.
    prod_s_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    prod_u_s = {32'd0, rs_data} * {32'd0, rt_data};
`endif
  end

  // Next-state and next-register logic for the IDLE/RUN/FIX sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    opb_d    = opb_q;
    op_div_d = op_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    rs_raw_d = rs_raw_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    start_s  = 1'b0;
    // funct bit0 clear selects the signed variant of MULT/DIV.
    sgn_a_s  = ~funct[0] & rs_data[31];
    sgn_b_s  = ~funct[0] & rt_data[31];

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (funct)
            F_MTHI: hi_d = rs_data;
            F_MTLO: lo_d = rs_data;
            F_MULT, F_MULTU: begin
`ifdef HILO_FAST_MULT_EN
              if (funct == F_MULT) begin
                {hi_d, lo_d} = prod_s_s;
              end else begin
                {hi_d, lo_d} = prod_u_s;
              end
`else
              start_s = 1'b1;
`endif
            end
            F_DIV, F_DIVU: start_s = 1'b1;
            default: start_s = 1'b0;
          endcase
        end else begin
          start_s = 1'b0;
        end
        if (start_s) begin
          state_d  = S_RUN;
          cnt_d    = 5'd0;
          rem_d    = 32'd0;
          quo_d    = neg32(rs_data, sgn_a_s);
          opb_d    = neg32(rt_data, sgn_b_s);
          op_div_d = funct[1];
          neg_q_d  = sgn_a_s ^ sgn_b_s;
          neg_r_d  = sgn_a_s;
          div0_d   = funct[1] & (rt_data == 32'd0);
          rs_raw_d = rs_data;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (op_div_q) begin
          rem_d = div_rem_s;
          quo_d = div_quo_s;
        end else begin
          rem_d = mul_rem_s;
          quo_d = mul_quo_s;
        end
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
          cnt_d   = 5'd0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_FIX: begin
        if (op_div_q) begin
          if (div0_q) begin
            lo_d = 32'hFFFF_FFFF;
            hi_d = rs_raw_q;
          end else begin
            lo_d = neg32(quo_q, neg_q_q);
            hi_d = neg32(rem_q, neg_r_q);
          end
        end else begin
          {hi_d, lo_d} = prod_fix_s;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      opb_q    <= 32'd0;
      op_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      rs_raw_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      opb_q    <= opb_d;
      op_div_q <= op_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      rs_raw_q <= rs_raw_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed vector table, randomized ops
// against a behavioural model, and hand-written multi-cycle corner sequences.
module tb_hilo_muldiv;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
`ifdef HILO_FAST_MULT_EN
  localparam int MULT_LAT = 0;
`else
  localparam int MULT_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue;
  logic [5:0]  funct;
  logic [1:0]  HI_write, LO_write;
  logic [31:0] rs_data, rt_data;
  logic [31:0] hi, lo;
  logic        busy;

  int checks = 0;
  int errors = 0;

  hilo_muldiv dut (
    .clk(clk), .reset(reset), .issue(issue), .funct(funct),
    .HI_write(HI_write), .LO_write(LO_write),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [1:0]  hw;
    logic [1:0]  lw;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [5:0] f, input logic [1:0] hw, input logic [1:0] lw,
                        input logic [31:0] rs, input logic [31:0] rt);
    funct = f; HI_write = hw; LO_write = lw; rs_data = rs; rt_data = rt;
  endtask

  // Issue for one edge, then count cycles with busy high (bounded).
  task automatic run_op(input logic [5:0] f, input logic [1:0] hw, input logic [1:0] lw,
                        input logic [31:0] rs, input logic [31:0] rt, output int lat);
    set_in(f, hw, lw, rs, rt);
    issue = 1'b1;
    @(posedge clk); #1;
    issue = 1'b0;
    lat = 0;
    while (busy && lat < 100) begin
      lat++;
      @(posedge clk); #1;
    end
  endtask

  // Reference result {hi,lo} from plain arithmetic on the operation's definition.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] rs,
                                        input logic [31:0] rt, input logic [31:0] cur_hi,
                                        input logic [31:0] cur_lo);
    longint      a, b, q, r;
    logic [63:0] p;
    case (f)
      F_MTHI: return {rs, cur_lo};
      F_MTLO: return {cur_hi, rs};
      F_MULT: begin
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        p = 64'(a * b);
        return p;
      end
      F_MULTU: begin
        p = {32'd0, rs} * {32'd0, rt};
        return p;
      end
      F_DIV: begin
        if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        q = a / b;
        r = a % b;
        return {r[31:0], q[31:0]};
      end
      F_DIVU: begin
        if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
        return {rs % rt, rs / rt};
      end
      default: return {cur_hi, cur_lo};
    endcase
  endfunction

  function automatic int model_lat(input logic [5:0] f);
    if (f == F_MULT || f == F_MULTU) return MULT_LAT;
    if (f == F_DIV || f == F_DIVU) return DIV_LAT;
    return 0;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tv[10];
    int          lat;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m;
    logic [5:0]  ops[6];
    logic [5:0]  f;
    logic [31:0] rs, rt;

    tv[0] = '{F_MTHI,  2'b11, 2'b00, 32'h12345678, 32'h0, 32'h12345678, 32'h0,        0};
    tv[1] = '{F_MTLO,  2'b00, 2'b11, 32'h9ABCDEF0, 32'h0, 32'h12345678, 32'h9ABCDEF0, 0};
    tv[2] = '{F_MULT,  2'b11, 2'b11, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, MULT_LAT};
    tv[3] = '{F_MULTU, 2'b11, 2'b11, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA, MULT_LAT};
    tv[4] = '{F_DIV,   2'b11, 2'b11, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
    tv[5] = '{F_DIVU,  2'b11, 2'b11, 32'd100,      32'd7, 32'd2,        32'd14,       DIV_LAT};
    tv[6] = '{F_DIVU,  2'b11, 2'b11, 32'h55,       32'h0, 32'h55,       32'hFFFFFFFF, DIV_LAT};
    tv[7] = '{F_DIV,   2'b11, 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, DIV_LAT};
    tv[8] = '{F_MULTU, 2'b00, 2'b00, 32'd5,        32'd5, 32'h0,        32'h80000000, 0};
    tv[9] = '{6'h10,   2'b11, 2'b11, 32'd5,        32'd5, 32'h0,        32'h80000000, 0};

    ops[0] = F_MTHI; ops[1] = F_MTLO; ops[2] = F_MULT;
    ops[3] = F_MULTU; ops[4] = F_DIV; ops[5] = F_DIVU;

    reset = 1'b1; issue = 1'b0;
    set_in(6'h0, 2'b00, 2'b00, 32'h0, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      run_op(tv[i].f, tv[i].hw, tv[i].lw, tv[i].rs, tv[i].rt, lat);
      check($sformatf("vec%0d_hi", i), hi, tv[i].exp_hi);
      check($sformatf("vec%0d_lo", i), lo, tv[i].exp_lo);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tv[i].exp_lat));
    end

    // Randomized operations against the model
    m_hi = tv[9].exp_hi;
    m_lo = tv[9].exp_lo;
    for (int i = 0; i < 40; i++) begin
      f  = ops[$urandom_range(0, 5)];
      rs = $urandom;
      rt = $urandom;
      case ($urandom_range(0, 7))
        0: rt = 32'd0;
        1: begin rs = 32'h80000000; rt = 32'hFFFFFFFF; end
        2: rt = 32'($urandom_range(1, 15));
        3: rs = 32'($urandom_range(0, 20));
        default: ;
      endcase
      m = model(f, rs, rt, m_hi, m_lo);
      m_hi = m[63:32];
      m_lo = m[31:0];
      run_op(f, 2'b11, 2'b11, rs, rt, lat);
      check($sformatf("rnd%0d_f%h_hi", i, f), hi, m_hi);
      check($sformatf("rnd%0d_f%h_lo", i, f), lo, m_lo);
      check($sformatf("rnd%0d_f%h_lat", i, f), 32'(lat), 32'(model_lat(f)));
    end

    // MTHI issued while a DIV is in flight is ignored
    set_in(F_DIV, 2'b11, 2'b11, 32'hFFFFFFF9, 32'd2);
    issue = 1'b1;
    @(posedge clk); #1;
    issue = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    set_in(F_MTHI, 2'b11, 2'b00, 32'hDEADBEEF, 32'h0);
    issue = 1'b1;
    @(posedge clk); #1;
    issue = 1'b0;
    lat = 0;
    while (busy && lat < 100) begin lat++; @(posedge clk); #1; end
    check("busy_mthi_hi", hi, 32'hFFFFFFFF);
    check("busy_mthi_lo", lo, 32'hFFFFFFFD);
    run_op(F_MTHI, 2'b11, 2'b00, 32'hDEADBEEF, 32'h0, lat);
    check("reissue_mthi_hi", hi, 32'hDEADBEEF);

    // Reset in the middle of a DIV abandons it
    set_in(F_DIVU, 2'b11, 2'b11, 32'd100, 32'd7);
    issue = 1'b1;
    @(posedge clk); #1;
    issue = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("mid_div_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_hi", hi, 32'h0);
    check("midreset_lo", lo, 32'h0);
    run_op(F_MULTU, 2'b11, 2'b11, 32'd3, 32'd5, lat);
    check("post_reset_mul_lo", lo, 32'd15);
    check("post_reset_mul_hi", hi, 32'd0);
    check("post_reset_mul_lat", 32'(lat), 32'(MULT_LAT));

    // Reset wins over a simultaneous issue
    set_in(F_MTLO, 2'b00, 2'b11, 32'hAAAA5555, 32'h0);
    issue = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    issue = 1'b0;
    reset = 1'b0;
    check("reset_vs_issue_lo", lo, 32'h0);
    check("reset_vs_issue_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
